// File: rtl/meas_sequencer_if.sv
// meas_sequencer_if
//   Signal bundle between the measurement sequencer and its surroundings.
//   master : the controller/sensor side (drives enable/start/cal_req/echo_in)
//   slave  : the sequencer itself (drives trigger, status and results)
//   SIZE sets the width of echo_out and config_N_ref.
interface meas_sequencer_if #(
    parameter int SIZE = 32
);
    logic            enable;
    logic            start;
    logic            cal_req;
    logic            echo_in;
    logic            trig_out;
    logic            busy;
    logic            echo_rdy;
    logic [SIZE-1:0] echo_out;
    logic [SIZE-1:0] config_N_ref;
    logic            cal_done;
    logic            timeout_err;

    modport master (
        output enable, start, cal_req, echo_in,
        input  trig_out, busy, echo_rdy, echo_out, config_N_ref, cal_done, timeout_err
    );

    modport slave (
        input  enable, start, cal_req, echo_in,
        output trig_out, busy, echo_rdy, echo_out, config_N_ref, cal_done, timeout_err
    );
endinterface

// File: rtl/meas_sequencer.sv
// meas_sequencer
//   Runs one ultrasonic measurement: trigger pulse, wait for the echo,
//   count the echo width, hand the result to the calculation path, then
//   hold off before the next cycle. A calibration request makes the next
//   successful echo count become the new reference (config_N_ref).
//
//   clk, rst_n     : system clock, asynchronous active-low reset
//   bus.enable     : free-running mode, start a cycle whenever idle
//   bus.start      : one-shot start pulse (ignored while busy)
//   bus.cal_req    : arm calibration for the next successful measurement
//   bus.echo_in    : raw asynchronous sensor echo
//   bus.trig_out   : sensor trigger, high for TRIG_CYCLES cycles
//   bus.busy       : high in every state except IDLE
//   bus.echo_rdy   : one-cycle pulse, echo_out was updated
//   bus.echo_out   : last valid echo width in clk cycles
//   bus.config_N_ref / bus.cal_done : reference count and its update pulse
//   bus.timeout_err: one-cycle pulse, cycle aborted by timeout
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | waiting for start or enable
//   TRIG      | trig_out high, counting TRIG_CYCLES
//   WAIT_ECHO | waiting for a rising edge of the synchronized echo
//   MEASURE   | counting cycles with echo high
//   HOLDOFF   | quiet time before returning to IDLE, echo edges ignored
module meas_sequencer #(
    parameter int              SIZE           = 32,
    parameter int              TRIG_CYCLES    = 1000,
    parameter int              TIMEOUT_CYCLES = 2500000,
    parameter int              HOLDOFF_CYCLES = 6000000,
    parameter logic [SIZE-1:0] N_REF_INIT     = 32'd100000
) (
    input logic               clk,
    input logic               rst_n,
    meas_sequencer_if.slave   bus
);

    localparam logic [SIZE-1:0] TRIG_LAST    = SIZE'(TRIG_CYCLES - 1);
    localparam logic [SIZE-1:0] WAIT_LAST    = SIZE'(TIMEOUT_CYCLES - 1);
    localparam logic [SIZE-1:0] MEAS_LIMIT   = SIZE'(TIMEOUT_CYCLES);
    localparam logic [SIZE-1:0] HOLDOFF_LAST = SIZE'(HOLDOFF_CYCLES - 1);
    localparam logic [SIZE-1:0] ONE          = SIZE'(1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic            trig_q, trig_d;
    logic            busy_q, busy_d;
    logic            echo_rdy_q, echo_rdy_d;
    logic [SIZE-1:0] echo_out_q, echo_out_d;
    logic [SIZE-1:0] n_ref_q, n_ref_d;
    logic            cal_done_q, cal_done_d;
    logic            timeout_q, timeout_d;
    logic            cal_pending_q, cal_pending_d;
    logic            echo_meta_q, echo_meta_d;
    logic            echo_s_q, echo_s_d;
    logic            echo_prev_q, echo_prev_d;

    logic            echo_rise;
    logic            echo_fall;
    logic            cal_armed;

    assign echo_rise = echo_s_q & ~echo_prev_q;
    assign echo_fall = ~echo_s_q & echo_prev_q;
    // A request arriving in the completing cycle still counts for that result.
    assign cal_armed = cal_pending_q | bus.cal_req;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        trig_d        = trig_q;
        echo_rdy_d    = 1'b0;
        cal_done_d    = 1'b0;
        timeout_d     = 1'b0;
        echo_out_d    = echo_out_q;
        n_ref_d       = n_ref_q;
        cal_pending_d = cal_armed;
        echo_meta_d   = bus.echo_in;
        echo_s_d      = echo_meta_q;
        echo_prev_d   = echo_s_q;

        case (state_q)
            IDLE: begin
                if (bus.start || bus.enable) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                    trig_d  = 1'b1;
                end
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                    trig_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    // The edge sample itself is the first high cycle.
                    state_d = MEASURE;
                    cnt_d   = ONE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_d    = HOLDOFF;
                    cnt_d      = '0;
                    echo_out_d = cnt_q;
                    echo_rdy_d = 1'b1;
                    if (cal_armed) begin
                        n_ref_d       = cnt_q;
                        cal_done_d    = 1'b1;
                        cal_pending_d = 1'b0;
                    end
                end else if (cnt_q == MEAS_LIMIT) begin
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLDOFF_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                trig_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            trig_q        <= 1'b0;
            busy_q        <= 1'b0;
            echo_rdy_q    <= 1'b0;
            echo_out_q    <= '0;
            n_ref_q       <= N_REF_INIT;
            cal_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
            cal_pending_q <= 1'b0;
            echo_meta_q   <= 1'b0;
            echo_s_q      <= 1'b0;
            echo_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            trig_q        <= trig_d;
            busy_q        <= busy_d;
            echo_rdy_q    <= echo_rdy_d;
            echo_out_q    <= echo_out_d;
            n_ref_q       <= n_ref_d;
            cal_done_q    <= cal_done_d;
            timeout_q     <= timeout_d;
            cal_pending_q <= cal_pending_d;
            echo_meta_q   <= echo_meta_d;
            echo_s_q      <= echo_s_d;
            echo_prev_q   <= echo_prev_d;
        end
    end

    assign bus.trig_out     = trig_q;
    assign bus.busy         = busy_q;
    assign bus.echo_rdy     = echo_rdy_q;
    assign bus.echo_out     = echo_out_q;
    assign bus.config_N_ref = n_ref_q;
    assign bus.cal_done     = cal_done_q;
    assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// tb_meas_sequencer
//   Directed bench for meas_sequencer with short timing parameters.
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_meas_sequencer;

    localparam int SIZE = 32;
    localparam int TRIG = 10;
    localparam int TMO  = 1000;
    localparam int HOLD = 50;
    localparam logic [SIZE-1:0] NREF0 = 32'd100000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    meas_sequencer_if #(.SIZE(SIZE)) bus ();

    meas_sequencer #(
        .SIZE(SIZE),
        .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO),
        .HOLDOFF_CYCLES(HOLD),
        .N_REF_INIT(NREF0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for trig_out, then counts its high cycles. Returns with
    // the first low sample current.
    task automatic wait_trig(output int len, output int rise_cyc);
        int n;
        n = 0;
        len = 0;
        rise_cyc = -1;
        while (!bus.trig_out && n < 200) begin
            step();
            n++;
        end
        if (bus.trig_out) rise_cyc = cyc;
        while (bus.trig_out && len < 200) begin
            len++;
            step();
        end
    endtask

    // One full measurement: optional start pulse, trigger, gap, echo of elen
    // cycles, then echo_rdy and busy timing.
    task automatic do_cycle(input bit do_start, input int elen, input int gap,
                            input bit drop_en,
                            output int tlen, output int trise, output int rdy_lat,
                            output bit cal_at_rdy, output bit rdy_after,
                            output int busy_lat);
        if (do_start) pulse_start();
        wait_trig(tlen, trise);
        repeat (gap) step();
        bus.echo_in = 1'b1;
        for (int i = 0; i < elen; i++) begin
            step();
            if (drop_en && i == elen / 2) bus.enable = 1'b0;
        end
        bus.echo_in = 1'b0;
        rdy_lat = -1;
        cal_at_rdy = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.echo_rdy) begin
                rdy_lat = i;
                cal_at_rdy = bus.cal_done;
                break;
            end
        end
        step();
        rdy_after = bus.echo_rdy;
        busy_lat = 1;
        while (bus.busy && busy_lat < 300) begin
            step();
            busy_lat++;
        end
    endtask

    initial begin
        int  tlen, trise, rdy_lat, busy_lat, to_lat, n, to_cnt, trig_cnt;
        int  rise1, rise2, rise3;
        bit  cal_at, rdy_after, rdy_seen;

        checks = 0;
        errors = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.start = 1'b0;
        bus.cal_req = 1'b0;
        bus.echo_in = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_trig", bus.trig_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdy", bus.echo_rdy, 0);
        chk("rst_echo_out", bus.echo_out, 0);
        chk("rst_nref", bus.config_N_ref, NREF0);
        chk("rst_cal_done", bus.cal_done, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        rst_n = 1'b1;
        repeat (5) step();
        chk("idle_busy", bus.busy, 0);

        // Basic 200-cycle echo
        do_cycle(1'b1, 200, 3, 1'b0, tlen, trise, rdy_lat, cal_at, rdy_after, busy_lat);
        chk("t1_trig_len", tlen, 10);
        chk("t1_echo_out", bus.echo_out, 200);
        chk("t1_rdy_lat", rdy_lat, 3);
        chk("t1_rdy_one_cycle", rdy_after, 0);
        chk("t1_busy_lat", busy_lat, 50);
        chk("t1_nref", bus.config_N_ref, NREF0);
        chk("t1_cal_done", cal_at, 0);

        // No echo: timeout 1000 cycles after trig falls
        pulse_start();
        wait_trig(tlen, trise);
        to_lat = -1;
        rdy_seen = 1'b0;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (bus.echo_rdy) rdy_seen = 1'b1;
            if (bus.timeout_err) begin
                to_lat = i;
                break;
            end
        end
        chk("t2_timeout_lat", to_lat, 1000);
        chk("t2_echo_out_kept", bus.echo_out, 200);
        step();
        chk("t2_timeout_one_cycle", bus.timeout_err, 0);
        n = 0;
        while (bus.busy && n < 200) begin
            if (bus.echo_rdy) rdy_seen = 1'b1;
            step();
            n++;
        end
        chk("t2_no_rdy", rdy_seen, 0);
        chk("t2_idle", bus.busy, 0);

        // Echo stuck high past the limit, late fall in HOLDOFF ignored
        pulse_start();
        wait_trig(tlen, trise);
        repeat (3) step();
        bus.echo_in = 1'b1;
        to_lat = -1;
        to_cnt = 0;
        rdy_seen = 1'b0;
        for (int i = 1; i <= 1020; i++) begin
            step();
            if (bus.echo_rdy) rdy_seen = 1'b1;
            if (bus.timeout_err) begin
                to_cnt++;
                if (to_lat < 0) to_lat = i;
            end
        end
        bus.echo_in = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            step();
            n++;
            if (bus.echo_rdy) rdy_seen = 1'b1;
            if (bus.timeout_err) to_cnt++;
        end
        chk("t3_timeout_lat", to_lat, 1003);
        chk("t3_timeout_pulses", to_cnt, 1);
        chk("t3_no_rdy", rdy_seen, 0);
        chk("t3_echo_out_kept", bus.echo_out, 200);
        chk("t3_idle", bus.busy, 0);

        // Calibration
        bus.cal_req = 1'b1;
        step();
        bus.cal_req = 1'b0;
        repeat (2) step();
        do_cycle(1'b1, 300, 3, 1'b0, tlen, trise, rdy_lat, cal_at, rdy_after, busy_lat);
        chk("t4_echo_out_300", bus.echo_out, 300);
        chk("t4_nref_300", bus.config_N_ref, 300);
        chk("t4_cal_with_rdy", cal_at, 1);
        chk("t4_cal_one_cycle", bus.cal_done, 0);
        do_cycle(1'b1, 400, 3, 1'b0, tlen, trise, rdy_lat, cal_at, rdy_after, busy_lat);
        chk("t4_echo_out_400", bus.echo_out, 400);
        chk("t4_nref_kept", bus.config_N_ref, 300);
        chk("t4_no_cal", cal_at, 0);

        // Free-running mode, period = 10 + 100 + 3 + 50 + 1
        bus.enable = 1'b1;
        do_cycle(1'b0, 100, 0, 1'b0, tlen, rise1, rdy_lat, cal_at, rdy_after, busy_lat);
        chk("t5_echo_out_a", bus.echo_out, 100);
        do_cycle(1'b0, 100, 0, 1'b0, tlen, rise2, rdy_lat, cal_at, rdy_after, busy_lat);
        do_cycle(1'b0, 100, 0, 1'b1, tlen, rise3, rdy_lat, cal_at, rdy_after, busy_lat);
        chk("t5_period_1", rise2 - rise1, 164);
        chk("t5_period_2", rise3 - rise2, 164);
        chk("t5_last_rdy", rdy_lat, 3);
        trig_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.trig_out || bus.busy) trig_cnt++;
        end
        chk("t5_stopped", trig_cnt, 0);

        // Reset during MEASURE; pending calibration must be lost
        bus.cal_req = 1'b1;
        step();
        bus.cal_req = 1'b0;
        pulse_start();
        wait_trig(tlen, trise);
        bus.echo_in = 1'b1;
        repeat (20) step();
        chk("t6_busy_before", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy_async", bus.busy, 0);
        chk("t6_trig_async", bus.trig_out, 0);
        chk("t6_echo_out_rst", bus.echo_out, 0);
        chk("t6_nref_rst", bus.config_N_ref, NREF0);
        bus.echo_in = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        trig_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.trig_out || bus.busy) trig_cnt++;
        end
        chk("t6_idles", trig_cnt, 0);
        do_cycle(1'b1, 50, 3, 1'b0, tlen, trise, rdy_lat, cal_at, rdy_after, busy_lat);
        chk("t6_echo_out_50", bus.echo_out, 50);
        chk("t6_cal_lost", cal_at, 0);
        chk("t6_nref_kept", bus.config_N_ref, NREF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
